// File: rtl/sdp_ram_fifo_pkg.sv
// sdp_ram_fifo_pkg
//   Shared defaults and types for the SDP-RAM FIFO slice.
//   Optional feature macro: SDP_RAM_FIFO_COUNT_EN (default undefined). When
//   defined, the FIFO top exposes a registered occupancy port named count.
//   Contents:
//     SDP_DATA_WIDTH_DFLT / SDP_ADDR_WIDTH_DFLT  default parameter values
//     sdp_xfer_t                                per-cycle handshake events
package sdp_ram_fifo_pkg;

  localparam int unsigned SDP_DATA_WIDTH_DFLT = 8;
  localparam int unsigned SDP_ADDR_WIDTH_DFLT = 4;

  // Events decided combinationally each cycle from the current state.
  typedef struct packed {
    logic push;  // word accepted from the producer into RAM
    logic pop;   // head word taken by the consumer
    logic load;  // head register refilled from RAM
  } sdp_xfer_t;

endpackage

// File: rtl/sdp_ram_core.sv
// sdp_ram_core
//   Distributed simple-dual-port RAM: synchronous write port, asynchronous
//   read port. No reset; contents are undefined until written.
//   Ports:
//     clock  in   write clock
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     raddr  in   read address
//     rdata  out  read data, combinational from raddr
module sdp_ram_core
  import sdp_ram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SDP_DATA_WIDTH_DFLT,
  parameter int unsigned ADDR_WIDTH = SDP_ADDR_WIDTH_DFLT
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* syn_ramstyle = "distributed" *)
  logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sdp_ram_fifo.sv
// sdp_ram_fifo
//   Synchronous valid/ready FIFO: 2^ADDR_WIDTH words in a distributed RAM
//   plus one registered head word on the output.
//   Optional feature macro: SDP_RAM_FIFO_COUNT_EN adds the count port.
//   Ports:
//     clock      in   single clock
//     resetn     in   asynchronous active-low reset
//     in_valid   in   producer offers in_data
//     in_ready   out  RAM not full (state only)
//     in_data    in   write word
//     out_valid  out  out_data holds the oldest word
//     out_ready  in   consumer takes out_data
//     out_data   out  registered head word
//     count      out  words held (RAM + head), only with SDP_RAM_FIFO_COUNT_EN
module sdp_ram_fifo
  import sdp_ram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SDP_DATA_WIDTH_DFLT,
  parameter int unsigned ADDR_WIDTH = SDP_ADDR_WIDTH_DFLT
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef SDP_RAM_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   count
`endif
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_empty, ram_full;
  sdp_xfer_t             xfer;

  sdp_ram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clock (clock),
    .we    (xfer.push),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  always_comb begin
    ram_empty = (wr_ptr_q == rd_ptr_q);
    ram_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

    xfer.push = in_valid & ~ram_full;
    xfer.pop  = out_valid_q & out_ready;
    // A load never reads the slot being written this cycle: it needs a
    // non-empty RAM, so rd_ptr cannot equal wr_ptr.
    xfer.load = ~ram_empty & (~out_valid_q | out_ready);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (xfer.push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (xfer.load) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      out_valid_d = 1'b1;
      out_data_d  = ram_rdata;
    end else if (xfer.pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = ~ram_full;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef SDP_RAM_FIFO_COUNT_EN
  // Occupancy is RAM words plus the head register, built from next-state
  // values so it moves on the same edge as the pointers.
  logic [ADDR_WIDTH:0] count_q, count_d;

  always_comb begin
    count_d = (wr_ptr_d - rd_ptr_d) + {{ADDR_WIDTH{1'b0}}, out_valid_d};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`endif

endmodule

// File: tb/tb_sdp_ram_fifo.sv
module tb_sdp_ram_fifo;

  localparam int RAM_DEPTH = 16;

  logic       clock = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef SDP_RAM_FIFO_COUNT_EN
  logic [4:0] count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of words held in RAM plus the head register.
  logic [7:0] m_ram[$];
  bit         m_hv;
  logic [7:0] m_hd;

  always #5 clock = ~clock;

  sdp_ram_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SDP_RAM_FIFO_COUNT_EN
    ,
    .count     (count)
`endif
  );

  function automatic int m_count();
    return m_ram.size() + (m_hv ? 1 : 0);
  endfunction

  task automatic model_reset();
    m_ram.delete();
    m_hv = 1'b0;
    m_hd = 8'h00;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, and return
  // 1 time unit after the edge, where outputs are sampled.
  task automatic tick(input bit iv, input logic [7:0] d, input bit ordy);
    bit push, pop, load;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clock);
    push = iv && (m_ram.size() < RAM_DEPTH);
    pop  = m_hv && ordy;
    load = (m_ram.size() != 0) && (!m_hv || ordy);
    if (load) begin
      m_hd = m_ram.pop_front();
      m_hv = 1'b1;
    end else if (pop) begin
      m_hv = 1'b0;
    end
    if (push) m_ram.push_back(d);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
`ifdef SDP_RAM_FIFO_COUNT_EN
    n_checks++;
    if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
`endif
    tick(0, 8'h00, 0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_state: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 17; k++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b expected 1", k, in_ready); end
      tick(1, 8'(k), 0);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got in_ready=%b expected 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_out_valid: got %b expected 1", out_valid); end
    n_checks++;
    if (out_data !== 8'h01) begin n_fail++; $display("FAIL fill_out_data: got %h expected 01", out_data); end
`ifdef SDP_RAM_FIFO_COUNT_EN
    n_checks++;
    if (count !== 5'd17) begin n_fail++; $display("FAIL fill_count: got %0d expected 17", count); end
`endif
    // Offer a word while full: it must be dropped.
    tick(1, 8'hFF, 0);
    n_checks++;
    if (in_ready !== 1'b0 || out_data !== 8'h01) begin
      n_fail++; $display("FAIL full_ignore: got ready=%b data=%h expected ready=0 data=01", in_ready, out_data);
    end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 17; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(k)) begin
        n_fail++; $display("FAIL drain_%0d: got valid=%b data=%h expected valid=1 data=%h", k, out_valid, out_data, 8'(k));
      end
      tick(0, 8'h00, 1);
      if (k == 1) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_rise: got %b expected 1", in_ready); end
      end
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got out_valid=%b expected 0", out_valid); end
`ifdef SDP_RAM_FIFO_COUNT_EN
    n_checks++;
    if (count !== 5'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", count); end
`endif
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 100; i++) begin
      tick(1, 8'(8'h20 + i - 1), 1);
      n_checks++;
      if (out_valid !== (i >= 2)) begin
        n_fail++; $display("FAIL stream_valid_%0d: got %b expected %b", i, out_valid, (i >= 2));
      end
      if (i >= 2) begin
        n_checks++;
        if (out_data !== 8'(8'h20 + i - 2)) begin
          n_fail++; $display("FAIL stream_data_%0d: got %h expected %h", i, out_data, 8'(8'h20 + i - 2));
        end
      end
    end
    tick(0, 8'h00, 1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'(8'h20 + 99)) begin
      n_fail++; $display("FAIL stream_tail: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, 8'(8'h20 + 99));
    end
    tick(0, 8'h00, 1);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] words [17];
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 17; k++) words[k] = 8'($urandom);
      for (int k = 0; k < 17; k++) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wrap%0d_ready_%0d: got %b expected 1", it, k, in_ready); end
        tick(1, words[k], 0);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL wrap%0d_full: got in_ready=%b expected 0", it, in_ready); end
      for (int k = 0; k < 17; k++) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== words[k]) begin
          n_fail++; $display("FAIL wrap%0d_data_%0d: got valid=%b data=%h expected valid=1 data=%h", it, k, out_valid, out_data, words[k]);
        end
        tick(0, 8'h00, 1);
      end
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL wrap%0d_empty: got valid=%b ready=%b expected valid=0 ready=1", it, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) tick(1, 8'(8'h50 + k), 0);
`ifdef SDP_RAM_FIFO_COUNT_EN
    n_checks++;
    if (count !== 5'd5) begin n_fail++; $display("FAIL mid_count_before: got %0d expected 5", count); end
`endif
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: got valid=%b data=%h ready=%b expected 0 00 1", out_valid, out_data, in_ready);
    end
`ifdef SDP_RAM_FIFO_COUNT_EN
    n_checks++;
    if (count !== 5'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected 0", count); end
`endif
    #3;
    resetn = 1'b1;
    tick(1, 8'hAA, 0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_lat1: got valid=%b expected 0", out_valid); end
    tick(0, 8'h00, 0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hAA) begin
      n_fail++; $display("FAIL post_reset_lat2: got valid=%b data=%h expected valid=1 data=aa", out_valid, out_data);
    end
    tick(0, 8'h00, 1);
  endtask

  task automatic test_random();
    int pin, pout;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        pin  = $urandom_range(20, 95);
        pout = $urandom_range(20, 95);
      end
      tick($urandom_range(0, 99) < pin, 8'($urandom), $urandom_range(0, 99) < pout);
      n_checks++;
      if (out_valid !== m_hv || in_ready !== (m_ram.size() < RAM_DEPTH) || out_data !== m_hd) begin
        n_fail++;
        $display("FAIL random_%0d: got valid=%b ready=%b data=%h expected valid=%b ready=%b data=%h",
                 i, out_valid, in_ready, out_data, m_hv, (m_ram.size() < RAM_DEPTH), m_hd);
      end
`ifdef SDP_RAM_FIFO_COUNT_EN
      n_checks++;
      if (count !== 5'(m_count())) begin
        n_fail++; $display("FAIL random_count_%0d: got %0d expected %0d", i, count, m_count());
      end
`endif
    end
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    model_reset();
    #12;
    resetn = 1'b1;
    #4;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
